// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller and its forwarding unit.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;

    localparam logic [1:0] FWD_RF   = 2'b00;
    localparam logic [1:0] FWD_MEM  = 2'b10;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Youngest writer wins: EX/MEM holds a newer value than MEM/WB.
    function automatic logic [1:0] fwd_pick(
        input logic [4:0] src,
        input logic [4:0] mem_rd,
        input logic       mem_we,
        input logic [4:0] wb_rd,
        input logic       wb_we
    );
        if (mem_we && mem_rd != REG_ZERO && mem_rd == src)
            return FWD_MEM;
        else if (wb_we && wb_rd != REG_ZERO && wb_rd == src)
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_fwd_unit.sv
// Combinational ALU operand forwarding; one select per EX source operand.
module fwd_unit
    import pipe_pkg::*;
#(
    parameter int NUM_OPS = 2
) (
    input  logic [NUM_OPS-1:0][4:0] ex_src_i,
    input  logic [4:0]              mem_rd_i,
    input  logic                    mem_we_i,
    input  logic [4:0]              wb_rd_i,
    input  logic                    wb_we_i,
    output logic [NUM_OPS-1:0][1:0] fwd_sel_o
);

    for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
        assign fwd_sel_o[g] = fwd_pick(ex_src_i[g], mem_rd_i, mem_we_i, wb_rd_i, wb_we_i);
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: stall, bubble, flush,
// memory wait freeze, forwarding selects, stall counter and sticky memory timeout.
module pipeline_ctrl
    import pipe_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 255,
    parameter int CNT_W        = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [4:0]       id_rs_addr,
    input  logic [4:0]       id_rt_addr,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [4:0]       ex_rs_addr,
    input  logic [4:0]       ex_rt_addr,
    input  logic [4:0]       ex_rd_addr,
    input  logic             ex_mem_read,
    input  logic             ex_jump,
    input  logic [4:0]       mem_rd_addr,
    input  logic             mem_reg_write,
    input  logic [4:0]       wb_rd_addr,
    input  logic             wb_reg_write,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_bubble,
    output logic             ex_mem_en,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_count,
    output logic             mem_timeout
);

    localparam logic [2:0]  FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [15:0] WAIT_MAX   = 16'(MEM_TIMEOUT);

    state_e           state_q, state_d;
    logic [2:0]       flush_cnt_q, flush_cnt_d;
    logic [15:0]      wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             timeout_q, timeout_d;

    logic             mem_wait, in_flush, jump_take, load_use;
    logic [1:0][4:0]  ex_src;
    logic [1:0][1:0]  fwd_sel;

    assign mem_wait  = dmem_req && !dmem_ready;
    // A flush interrupted by a memory wait resumes once the access completes.
    assign in_flush  = (state_q == FLUSH) || (state_q == MEM_WAIT && flush_cnt_q != 3'd0);
    assign jump_take = ex_jump && !in_flush;
    assign load_use  = ex_mem_read && (ex_rd_addr != REG_ZERO) &&
                       ((id_uses_rs && id_rs_addr == ex_rd_addr) ||
                        (id_uses_rt && id_rt_addr == ex_rd_addr));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RUN;
            flush_cnt_q <= 3'd0;
            wait_cnt_q  <= 16'd0;
            stall_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        wait_cnt_d  = 16'd0;
        timeout_d   = timeout_q;
        if (mem_wait) begin
            state_d    = MEM_WAIT;
            wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + 16'd1;
            if (wait_cnt_d == WAIT_MAX)
                timeout_d = 1'b1;
        end else if (in_flush) begin
            flush_cnt_d = flush_cnt_q - 3'd1;
            state_d     = (flush_cnt_q == 3'd1) ? RUN : FLUSH;
        end else if (jump_take) begin
            flush_cnt_d = FLUSH_LOAD;
            state_d     = (FLUSH_LOAD != 3'd0) ? FLUSH : RUN;
        end else begin
            flush_cnt_d = 3'd0;
            state_d     = RUN;
        end
        stall_cnt_d = (!pc_en && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    end

    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_en     = 1'b1;
        id_ex_bubble = 1'b0;
        ex_mem_en    = 1'b1;
        if (!reset_n) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_en     = 1'b0;
            id_ex_bubble = 1'b1;
            ex_mem_en    = 1'b0;
        end else if (mem_wait) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
        end else if (in_flush || jump_take) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (load_use) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

    assign ex_src = {ex_rt_addr, ex_rs_addr};

    fwd_unit #(.NUM_OPS(2)) u_fwd (
        .ex_src_i  (ex_src),
        .mem_rd_i  (mem_rd_addr),
        .mem_we_i  (mem_reg_write),
        .wb_rd_i   (wb_rd_addr),
        .wb_we_i   (wb_reg_write),
        .fwd_sel_o (fwd_sel)
    );

    assign fwd_a       = reset_n ? fwd_sel[0] : FWD_RF;
    assign fwd_b       = reset_n ? fwd_sel[1] : FWD_RF;
    assign stall_count = stall_cnt_q;
    assign mem_timeout = timeout_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: vector table for combinational decisions,
// hand sequences for flush, memory wait, timeout and async reset.
module tb_pipeline_ctrl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [4:0]  id_rs_addr, id_rt_addr, ex_rs_addr, ex_rt_addr, ex_rd_addr;
    logic [4:0]  mem_rd_addr, wb_rd_addr;
    logic        id_uses_rs, id_uses_rt, ex_mem_read, ex_jump;
    logic        mem_reg_write, wb_reg_write, dmem_req, dmem_ready;
    logic        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_count;
    logic        mem_timeout;
    logic [5:0]  ctrl;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    assign ctrl = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en};

    pipeline_ctrl #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(4), .CNT_W(16)) dut (
        .clock(clock), .reset_n(reset_n),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_rs_addr(ex_rs_addr), .ex_rt_addr(ex_rt_addr), .ex_rd_addr(ex_rd_addr),
        .ex_mem_read(ex_mem_read), .ex_jump(ex_jump),
        .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write),
        .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_en(id_ex_en), .id_ex_bubble(id_ex_bubble), .ex_mem_en(ex_mem_en),
        .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_count(stall_count), .mem_timeout(mem_timeout)
    );

    // ctrl = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en}
    localparam logic [5:0] C_RUN   = 6'b110101;
    localparam logic [5:0] C_LU    = 6'b000111;
    localparam logic [5:0] C_FRZ   = 6'b000000;
    localparam logic [5:0] C_FLUSH = 6'b111111;
    localparam logic [5:0] C_RST   = 6'b001010;

    typedef struct {
        string      name;
        logic [4:0] id_rs, id_rt;
        logic       uses_rs, uses_rt;
        logic [4:0] ex_rs, ex_rt, ex_rd;
        logic       ex_mr;
        logic [4:0] mem_rd;
        logic       mem_we;
        logic [4:0] wb_rd;
        logic       wb_we;
        logic       dreq, drdy;
        logic [5:0] ctrl;
        logic [1:0] fa, fb;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        id_rs_addr = 5'd0; id_rt_addr = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        ex_rs_addr = 5'd0; ex_rt_addr = 5'd0; ex_rd_addr = 5'd0;
        ex_mem_read = 1'b0; ex_jump = 1'b0;
        mem_rd_addr = 5'd0; mem_reg_write = 1'b0;
        wb_rd_addr = 5'd0; wb_reg_write = 1'b0;
        dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        clear_inputs();
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{"idle",       5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_RUN, 2'b00, 2'b00};
        vecs[1]  = '{"lu_rs",      5'd8, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd8, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_LU,  2'b00, 2'b00};
        vecs[2]  = '{"lu_rt",      5'd0, 5'd9, 1'b0, 1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_LU,  2'b00, 2'b00};
        vecs[3]  = '{"lu_r0",      5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_RUN, 2'b00, 2'b00};
        vecs[4]  = '{"lu_nouse",   5'd8, 5'd8, 1'b0, 1'b0, 5'd0, 5'd0, 5'd8, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_RUN, 2'b00, 2'b00};
        vecs[5]  = '{"no_load",    5'd8, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd8, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_RUN, 2'b00, 2'b00};
        vecs[6]  = '{"memwait",    5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_FRZ, 2'b00, 2'b00};
        vecs[7]  = '{"memready",   5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, C_RUN, 2'b00, 2'b00};
        vecs[8]  = '{"memwait_lu", 5'd8, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd8, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_FRZ, 2'b00, 2'b00};
        vecs[9]  = '{"fwd_memwin", 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 5'd0, 5'd0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, C_RUN, 2'b10, 2'b00};
        vecs[10] = '{"fwd_wb",     5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, C_RUN, 2'b01, 2'b00};
        vecs[11] = '{"fwd_zero",   5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, C_RUN, 2'b00, 2'b00};
        vecs[12] = '{"fwdb_wb",    5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd7, 5'd0, 1'b0, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, C_RUN, 2'b00, 2'b01};
        vecs[13] = '{"fwd_both",   5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 5'd3, 5'd0, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, C_RUN, 2'b10, 2'b10};
        vecs[14] = '{"fwd_wb_off", 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, C_RUN, 2'b00, 2'b00};
        vecs[15] = '{"fwd_split",  5'd0, 5'd0, 1'b0, 1'b0, 5'd4, 5'd6, 5'd0, 1'b0, 5'd4, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, C_RUN, 2'b10, 2'b01};

        // Reset state, with inputs that would otherwise forward
        reset_n = 1'b0;
        clear_inputs();
        ex_rs_addr = 5'd5; mem_rd_addr = 5'd5; mem_reg_write = 1'b1;
        #1;
        chk("rst_ctrl",    32'(ctrl), 32'(C_RST));
        chk("rst_fwd_a",   32'(fwd_a), 32'd0);
        chk("rst_stall",   32'(stall_count), 32'd0);
        chk("rst_timeout", 32'(mem_timeout), 32'd0);
        do_reset();

        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            id_rs_addr = vecs[i].id_rs;   id_rt_addr = vecs[i].id_rt;
            id_uses_rs = vecs[i].uses_rs; id_uses_rt = vecs[i].uses_rt;
            ex_rs_addr = vecs[i].ex_rs;   ex_rt_addr = vecs[i].ex_rt;
            ex_rd_addr = vecs[i].ex_rd;   ex_mem_read = vecs[i].ex_mr;
            mem_rd_addr = vecs[i].mem_rd; mem_reg_write = vecs[i].mem_we;
            wb_rd_addr = vecs[i].wb_rd;   wb_reg_write = vecs[i].wb_we;
            dmem_req = vecs[i].dreq;      dmem_ready = vecs[i].drdy;
            ex_jump = 1'b0;
            #1;
            chk({vecs[i].name, "_ctrl"}, 32'(ctrl), 32'(vecs[i].ctrl));
            chk({vecs[i].name, "_fa"},   32'(fwd_a), 32'(vecs[i].fa));
            chk({vecs[i].name, "_fb"},   32'(fwd_b), 32'(vecs[i].fb));
        end

        // Load-use: single stall cycle
        do_reset();
        @(negedge clock);
        ex_mem_read = 1'b1; ex_rd_addr = 5'd8; id_rs_addr = 5'd8; id_uses_rs = 1'b1;
        #1 chk("lu_seq_stall", 32'(ctrl), 32'(C_LU));
        @(negedge clock);
        clear_inputs();
        #1 chk("lu_seq_resume", 32'(ctrl), 32'(C_RUN));
        chk("lu_seq_count", 32'(stall_count), 32'd1);

        // Jump with 2 flush cycles; second jump during flush is a bubble
        do_reset();
        @(negedge clock); ex_jump = 1'b1;
        #1 chk("jmp_c1", 32'(ctrl), 32'(C_FLUSH));
        @(negedge clock); ex_jump = 1'b1;
        #1 chk("jmp_c2", 32'(ctrl), 32'(C_FLUSH));
        @(negedge clock); ex_jump = 1'b0;
        #1 chk("jmp_c3", 32'(ctrl), 32'(C_RUN));
        @(negedge clock);
        #1 chk("jmp_c4", 32'(ctrl), 32'(C_RUN));

        // Memory wait with a pending jump
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            @(negedge clock);
            dmem_req = 1'b1; dmem_ready = 1'b0; ex_jump = 1'b1;
            #1 chk($sformatf("mw_frz%0d", i), 32'(ctrl), 32'(C_FRZ));
        end
        @(negedge clock); dmem_ready = 1'b1;
        #1 chk("mw_ready_jmp", 32'(ctrl), 32'(C_FLUSH));
        chk("mw_stall3", 32'(stall_count), 32'd3);
        @(negedge clock); dmem_req = 1'b0; dmem_ready = 1'b0; ex_jump = 1'b0;
        #1 chk("mw_flush2", 32'(ctrl), 32'(C_FLUSH));
        @(negedge clock);
        #1 chk("mw_run", 32'(ctrl), 32'(C_RUN));
        chk("mw_stall_hold", 32'(stall_count), 32'd3);

        // Timeout: flag registered at the end of the 4th wait cycle
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            @(negedge clock);
            dmem_req = 1'b1; dmem_ready = 1'b0;
            #1 chk($sformatf("to_wait%0d", i), 32'(mem_timeout), (i > 4) ? 32'd1 : 32'd0);
        end
        @(negedge clock); dmem_ready = 1'b1;
        #1 chk("to_ready_ctrl", 32'(ctrl), 32'(C_RUN));
        chk("to_ready_flag", 32'(mem_timeout), 32'd1);
        chk("to_stall6", 32'(stall_count), 32'd6);
        @(negedge clock); dmem_req = 1'b0; dmem_ready = 1'b0;
        #1 chk("to_sticky", 32'(mem_timeout), 32'd1);
        #2 reset_n = 1'b0;
        #1 chk("to_reset_clr", 32'(mem_timeout), 32'd0);

        // Async reset in the middle of a flush
        do_reset();
        @(negedge clock);
        ex_mem_read = 1'b1; ex_rd_addr = 5'd8; id_rs_addr = 5'd8; id_uses_rs = 1'b1;
        @(negedge clock);
        clear_inputs(); ex_jump = 1'b1;
        #1 chk("ar_jump", 32'(ctrl), 32'(C_FLUSH));
        chk("ar_stall1", 32'(stall_count), 32'd1);
        @(negedge clock); ex_jump = 1'b0;
        ex_rs_addr = 5'd5; mem_rd_addr = 5'd5; mem_reg_write = 1'b1;
        #1 chk("ar_inflush", 32'(ctrl), 32'(C_FLUSH));
        chk("ar_fwd_pre", 32'(fwd_a), 32'(2'b10));
        #1 reset_n = 1'b0;
        #1 chk("ar_ctrl", 32'(ctrl), 32'(C_RST));
        chk("ar_fwd", 32'(fwd_a), 32'd0);
        chk("ar_stall0", 32'(stall_count), 32'd0);
        @(negedge clock);
        clear_inputs();
        reset_n = 1'b1;
        @(negedge clock);
        #1 chk("ar_post_run", 32'(ctrl), 32'(C_RUN));
        chk("ar_post_stall", 32'(stall_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
